// File: rtl/counter_snapshot_fifo.sv
// Snapshot FIFO that captures upstream counter values on a strobe or on a max-hit
// event and presents them to a valid/ready consumer, with drop accounting.
module counter_snapshot_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           cnt_in,
  input  logic                       capture,
  input  logic                       max_cap_en,
  output logic [WIDTH-1:0]           snap_data,
  output logic                       snap_is_max,
  output logic                       snap_valid,
  input  logic                       snap_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic [7:0]                 drop_count,
  input  logic                       clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]  wptr;
  logic [PW-1:0]  rptr;
  logic [WIDTH:0] mem [DEPTH];
  logic           prev_max;

  logic           cnt_is_max;
  logic           max_hit;
  logic           push_req;
  logic           pop;
  logic           push_ok;
  logic           drop;
  logic [WIDTH:0] head;

  // Rising-edge detect on the all-ones condition so a counter parked at max fires once.
  assign cnt_is_max = (cnt_in == {WIDTH{1'b1}});
  assign max_hit    = max_cap_en & cnt_is_max & ~prev_max;
  assign push_req   = capture | max_hit;

  assign empty      = (wptr == rptr);
  assign full       = ((wptr ^ rptr) == {1'b1, {AW{1'b0}}});
  assign level      = wptr - rptr;

  assign pop        = ~empty & snap_ready;
  assign push_ok    = push_req & (~full | pop);
  assign drop       = push_req & full & ~pop;

  assign head        = mem[rptr[AW-1:0]];
  assign snap_valid  = ~empty;
  assign snap_data   = head[WIDTH-1:0];
  assign snap_is_max = head[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_max <= 1'b0;
    end else begin
      prev_max <= cnt_is_max;
    end
  end

  // Storage is reset so the head reads as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push_ok) begin
      mem[wptr[AW-1:0]] <= {max_hit, cnt_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
    end
  end

  // A clear coinciding with a drop keeps only that newest drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else if (clr_ovf) begin
      overflow   <= drop;
      drop_count <= drop ? 8'd1 : 8'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

endmodule

// File: doc/counter_snapshot_fifo.md
Name: counter_snapshot_fifo

Overview:
- Sits directly downstream of the counter DUT. It samples the live count value into a small FIFO on an explicit capture strobe, or automatically when the count reaches its maximum value.
- Presents captured entries to a consumer over a valid/ready interface, for example a readout stage or the monitor-facing interface.
- Tracks FIFO occupancy and counts captures dropped because the FIFO was full.

Parameters:
- WIDTH, 8, width of the counter value being sampled.
- DEPTH, 4, number of FIFO entries. Must be a power of two, at least 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cnt_in  input  WIDTH  current counter value from the upstream counter.
- capture  input  1  sample cnt_in this cycle.
- max_cap_en  input  1  enables automatic capture on reaching all-ones.
- snap_data  output  WIDTH  head-entry count value.
- snap_is_max  output  1  head entry was produced by a max-hit event.
- snap_valid  output  1  the head entry is valid.
- snap_ready  input  1  the consumer accepts the head entry.
- level  output  $clog2(DEPTH)+1  number of stored entries.
- full  output  1  level == DEPTH.
- empty  output  1  level == 0.
- overflow  output  1  sticky: at least one capture has been dropped.
- drop_count  output  8  number of dropped captures; saturates at 255.
- clr_ovf  input  1  clears overflow and drop_count.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous, active-low, and named rst_n; the clock is named clk.
- Reset values:
  - All FIFO pointers are 0 and level is 0.
  - empty=1, full=0, snap_valid=0, overflow=0, drop_count=0.
  - snap_data and snap_is_max are 0.
  - The previous-value register prev_max is 0.
- Max detection:
  - prev_max registers (cnt_in == all-ones) every cycle.
  - max_hit = max_cap_en & (cnt_in == all-ones) & ~prev_max. This is rising-edge detection, so a counter that holds at max produces only one event.
- Push event: push_req = capture | max_hit. The stored entry is {max_hit, cnt_in}. If capture and max_hit occur in the same cycle, one entry is written with is_max=1.
- Pop: pop = snap_valid & snap_ready.
- Latency: an entry pushed at edge N is visible on snap_data/snap_valid after edge N, i.e. in cycle N+1. There is no combinational path from cnt_in or capture to the outputs.
- Head presentation:
  - snap_valid = ~empty.
  - snap_data and snap_is_max always reflect the memory head (read pointer).
  - While snap_valid=1 and snap_ready=0, the head entry is held stable.
- Level update:
  - Push accepted when level < DEPTH, or when level == DEPTH and pop in the same cycle.
  - Push only: level+1. Pop only: level-1. Both accepted: level unchanged, both pointers advance.
- Full and not popping: push_req is dropped.
  - overflow is set to 1.
  - drop_count increments, saturating at 255.
  - FIFO contents are unchanged.
- Pop when empty: snap_ready is ignored and no state changes.
- Pointers: log2(DEPTH)+1 bits with an extra wrap bit.
  - full = (wptr ^ rptr) == {1, zeros}.
  - empty = (wptr == rptr).
  - Pointers wrap modulo 2·DEPTH.
- clr_ovf:
  - Synchronous: overflow and drop_count become 0 at the next edge.
  - If a drop occurs in the same cycle, the clear wins except for the new drop: overflow=1, drop_count=1.
  - clr_ovf does not affect FIFO contents.
- Reset mid-operation: asserting rst_n=0 immediately empties the FIFO (asynchronous) and discards all entries, overflow state and prev_max.
- max_cap_en=0: prev_max still tracks, so re-enabling while cnt_in is held at max does not generate an event.

Test Plan:
- Basic capture: reset; cnt_in=8'h05, capture for 1 cycle, snap_ready=0 -> next cycle snap_valid=1, snap_data=05, snap_is_max=0, level=1. Then snap_ready=1 for 1 cycle -> empty=1, level=0.
- Max hit:
  - Stimulus: max_cap_en=1, counter runs FD, FE, FF, FF, 00.
  - Required: exactly one entry {1, FF}.
  - Required: with capture also asserted on the first FF cycle, still one entry, is_max=1.
- Fill and overflow:
  - Stimulus: DEPTH=4, snap_ready=0, capture 6 times with values 1..6.
  - Required: full=1 after the 4th, overflow=1, drop_count=2.
  - Required: draining yields 1, 2, 3, 4 in order; clr_ovf then gives overflow=0, drop_count=0.
- Simultaneous push/pop at full: FIFO full with 1..4; capture cnt_in=9 with snap_ready=1 in the same cycle -> no drop, level stays 4, subsequent drain gives 2, 3, 4, 9.
- Pointer wrap: 20 push/pop pairs with staggered ready (ready every other cycle) -> output order equals input order, no drops, level never exceeds DEPTH.
- Async reset mid-operation: with 3 entries and overflow=1, pulse rst_n low between clock edges -> outputs immediately show empty=1, snap_valid=0, level=0, overflow=0, drop_count=0.
